// File: rtl/mlp_pkg.sv
// mlp_pkg: types and sizing helpers shared by the MLP layer buffer and its
// output serializer.
//   buf_state_e : IDLE / FILL / DRAIN state of the layer buffer
//   DW_DEF      : default element width (bits)
//   N_DEF       : default matrix dimension
//   elem_t      : one signed matrix element at the default width
//   epb_f       : elements carried by one output beat
//   beats_f     : number of output beats needed for one N x N matrix
//   idx_w_f     : index width for a count, at least 1 bit
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } buf_state_e;

  localparam int DW_DEF = 16;
  localparam int N_DEF  = 16;

  typedef logic signed [DW_DEF-1:0] elem_t;

  function automatic int epb_f(input int out_w, input int dw);
    return out_w / dw;
  endfunction

  function automatic int beats_f(input int n, input int out_w, input int dw);
    return (n * n) / (out_w / dw);
  endfunction

  function automatic int idx_w_f(input int count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

endpackage

// File: rtl/mlp_out_serializer.sv
// mlp_out_serializer: turns the rows of one stored N x N matrix into a stream
// of OUT_W-bit beats. The parent supplies the row selected by row_idx_o; this
// block walks the beat index and slices the row.
//
// Handshake: a beat transfers on a cycle where out_valid_o && out_ready_i.
// Once out_valid_o is high it stays high, and out_data_o / out_last_o hold,
// until that beat transfers.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start_i         1-cycle pulse: begin streaming from beat 0
//   row_data_i      N*DW bits, row row_idx_o of the matrix being streamed
//   row_idx_o       row the current beat is taken from
//   out_valid_o     beat valid
//   out_ready_i     downstream ready
//   out_data_o      beat data, lowest column index in the MSBs (0 when idle)
//   out_last_o      current beat is the final beat of the matrix
//   last_accept_o   final beat transfers this cycle (combinational)
//   done_o          1-cycle pulse the cycle after the final beat transfers
module mlp_out_serializer
  import mlp_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int N     = N_DEF,
  parameter int OUT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [N*DW-1:0]        row_data_i,
  output logic [idx_w_f(N)-1:0]  row_idx_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [OUT_W-1:0]       out_data_o,
  output logic                   out_last_o,
  output logic                   last_accept_o,
  output logic                   done_o
);

  localparam int EPB   = epb_f(OUT_W, DW);
  localparam int BEATS = beats_f(N, OUT_W, DW);
  localparam int BPR   = N / EPB;               // beats per row
  localparam int BW    = idx_w_f(BEATS);
  localparam int RW    = idx_w_f(N);

  logic          valid_q, valid_d;
  logic [BW-1:0] beat_q, beat_d;
  logic          done_q, done_d;
  logic          handshake;
  logic          is_last;
  logic [OUT_W-1:0] beat_data;

  always_comb begin
    is_last   = (beat_q == BW'(BEATS - 1));
    handshake = valid_q && out_ready_i;
    valid_d   = valid_q;
    beat_d    = beat_q;
    done_d    = 1'b0;
    if (start_i) begin
      valid_d = 1'b1;
      beat_d  = '0;
    end else if (handshake) begin
      if (is_last) begin
        valid_d = 1'b0;
        beat_d  = '0;
        done_d  = 1'b1;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // Beat b lives in row b / BPR; within that row it carries the EPB columns
  // starting at (b % BPR) * EPB, first column placed in the top slice.
  always_comb begin
    int unsigned b;
    int unsigned chunk;
    int unsigned col;
    b         = 32'(beat_q);
    chunk     = b % BPR;
    row_idx_o = RW'(b / BPR);
    beat_data = '0;
    for (int e = 0; e < EPB; e++) begin
      col = chunk * EPB + e;
      beat_data[(EPB-1-e)*DW +: DW] = row_data_i[col*DW +: DW];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      beat_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      beat_q  <= beat_d;
      done_q  <= done_d;
    end
  end

  assign out_valid_o   = valid_q;
  assign out_data_o    = valid_q ? beat_data : '0;
  assign out_last_o    = valid_q && is_last;
  assign last_accept_o = handshake && is_last;
  assign done_o        = done_q;

endmodule

// File: rtl/mlp_layer_buffer.sv
// mlp_layer_buffer: double-buffered activation store for the MLP accelerator.
// Row-groups from the PE-array rounder are written into the write bank; the
// other bank (the last completed layer) is readable by row for the next layer.
// After the final layer of a frame the completed matrix is streamed out.
//
// Build option: define MLP_BUF_RELU_EN to clamp negative elements to zero as
// they are written. Without it elements are stored unmodified.
//
// Output handshake: a beat transfers on a cycle where out_valid_o &&
// out_ready_i; out_data_o / out_last_o hold while out_valid_o && !out_ready_i.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   wr_valid_i     rounder group valid
//   wr_data_i      RPW rows; row r at [r*N*DW +: N*DW], col c at [c*DW +: DW]
//   rd_row_i       row index for next-layer read
//   rd_data_o      row rd_row_i of the last completed layer (0 before any)
//   out_valid_o    result beat valid
//   out_ready_i    downstream ready
//   out_data_o     result beat
//   out_last_o     final beat of the frame
//   layer_o        layers completed in the current frame
//   busy_o         state != IDLE
//   frame_done_o   1-cycle pulse after the final beat transfers
//   overflow_o     sticky: a group arrived while draining
//   state_o        current FSM state (debug)
module mlp_layer_buffer
  import mlp_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int N          = N_DEF,
  parameter int RPW        = 2,
  parameter int OUT_W      = 32,
  parameter int NUM_LAYERS = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        wr_valid_i,
  input  logic [RPW*N*DW-1:0]         wr_data_i,
  input  logic [$clog2(N)-1:0]        rd_row_i,
  output logic [N*DW-1:0]             rd_data_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [OUT_W-1:0]            out_data_o,
  output logic                        out_last_o,
  output logic [$clog2(NUM_LAYERS):0] layer_o,
  output logic                        busy_o,
  output logic                        frame_done_o,
  output logic                        overflow_o,
  output buf_state_e                  state_o
);

  localparam int GPL = N / RPW;                  // groups per layer
  localparam int GW  = idx_w_f(GPL);
  localparam int RW  = idx_w_f(N);
  localparam int LW  = $clog2(NUM_LAYERS) + 1;

  buf_state_e    state_q, state_d;
  logic          wr_bank_q, wr_bank_d;
  logic [GW-1:0] grp_q, grp_d;
  logic [LW-1:0] layer_q, layer_d;
  logic          have_data_q, have_data_d;
  logic          overflow_q, overflow_d;
  logic          drain_start_q, drain_start_d;

  logic          wr_accept;
  logic          layer_end;
  logic          last_accept;
  logic [RW-1:0]   wr_row_idx  [RPW];
  logic [N*DW-1:0] wr_row_data [RPW];
  logic [RW-1:0]   ser_row_idx;
  logic [N*DW-1:0] ser_row_data;

  // Two banks of N rows, addressed as {bank, row}.
  logic [N*DW-1:0] mem_q [2*N];

  function automatic logic [N*DW-1:0] relu_row(input logic [N*DW-1:0] row);
    logic [N*DW-1:0] res;
    res = row;
`ifdef MLP_BUF_RELU_EN
    for (int c = 0; c < N; c++) begin
      if (row[c*DW + DW - 1]) res[c*DW +: DW] = '0;
    end
`endif
    return res;
  endfunction

  always_comb begin
    state_d       = state_q;
    wr_bank_d     = wr_bank_q;
    grp_d         = grp_q;
    layer_d       = layer_q;
    have_data_d   = have_data_q;
    overflow_d    = overflow_q;
    drain_start_d = 1'b0;

    wr_accept = wr_valid_i && (state_q != DRAIN);
    layer_end = wr_accept && (grp_q == GW'(GPL - 1));

    // Groups arriving during DRAIN are dropped; the drained bank stays intact.
    if (wr_valid_i && (state_q == DRAIN)) overflow_d = 1'b1;

    // Completing a layer flips banks so the finished layer becomes readable.
    if (wr_accept) begin
      if (layer_end) begin
        grp_d       = '0;
        wr_bank_d   = ~wr_bank_q;
        layer_d     = layer_q + 1'b1;
        have_data_d = 1'b1;
      end else begin
        grp_d = grp_q + 1'b1;
      end
    end

    case (state_q)
      IDLE:    if (wr_accept) state_d = FILL;
      FILL:    ;
      DRAIN: begin
        if (last_accept) begin
          state_d = IDLE;
          layer_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Final layer of the frame complete: stream it out. Covers the case where
    // a single group finishes the frame straight from IDLE.
    if (layer_end && (layer_q == LW'(NUM_LAYERS - 1))) begin
      state_d       = DRAIN;
      drain_start_d = 1'b1;
    end
  end

  always_comb begin
    for (int r = 0; r < RPW; r++) begin
      wr_row_idx[r]  = RW'(int'(grp_q) * RPW + r);
      wr_row_data[r] = relu_row(wr_data_i[r*N*DW +: N*DW]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_bank_q     <= 1'b0;
      grp_q         <= '0;
      layer_q       <= '0;
      have_data_q   <= 1'b0;
      overflow_q    <= 1'b0;
      drain_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      grp_q         <= grp_d;
      layer_q       <= layer_d;
      have_data_q   <= have_data_d;
      overflow_q    <= overflow_d;
      drain_start_q <= drain_start_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_accept) begin
      for (int r = 0; r < RPW; r++) begin
        mem_q[{wr_bank_q, wr_row_idx[r]}] <= wr_row_data[r];
      end
    end
  end

  assign rd_data_o    = have_data_q ? mem_q[{~wr_bank_q, rd_row_i}] : '0;
  assign ser_row_data = mem_q[{~wr_bank_q, ser_row_idx}];

  mlp_out_serializer #(
    .DW    (DW),
    .N     (N),
    .OUT_W (OUT_W)
  ) u_ser (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (drain_start_q),
    .row_data_i    (ser_row_data),
    .row_idx_o     (ser_row_idx),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_data_o    (out_data_o),
    .out_last_o    (out_last_o),
    .last_accept_o (last_accept),
    .done_o        (frame_done_o)
  );

  assign layer_o    = layer_q;
  assign busy_o     = (state_q != IDLE);
  assign overflow_o = overflow_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mlp_layer_buffer.sv
module tb_mlp_layer_buffer;
  import mlp_pkg::*;

  localparam int DW = 16, N = 16, RPW = 2, OUT_W = 32;
  localparam int GPL = N / RPW;
  localparam int BEATS = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // ---------------- DUT with one layer per frame ----------------
  logic wv1, rdy1, ov1, ol1, busy1, fd1, of1;
  logic [RPW*N*DW-1:0] wd1;
  logic [3:0] rr1;
  logic [N*DW-1:0] rd1;
  logic [31:0] od1;
  logic [0:0] lay1;
  buf_state_e st1;

  mlp_layer_buffer #(.DW(DW), .N(N), .RPW(RPW), .OUT_W(OUT_W), .NUM_LAYERS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_valid_i(wv1), .wr_data_i(wd1), .rd_row_i(rr1),
    .rd_data_o(rd1), .out_valid_o(ov1), .out_ready_i(rdy1), .out_data_o(od1),
    .out_last_o(ol1), .layer_o(lay1), .busy_o(busy1), .frame_done_o(fd1),
    .overflow_o(of1), .state_o(st1)
  );

  // ---------------- DUT with eight layers per frame ----------------
  logic wv8, rdy8, ov8, ol8, busy8, fd8, of8;
  logic [RPW*N*DW-1:0] wd8;
  logic [3:0] rr8;
  logic [N*DW-1:0] rd8;
  logic [31:0] od8;
  logic [3:0] lay8;
  buf_state_e st8;

  mlp_layer_buffer #(.DW(DW), .N(N), .RPW(RPW), .OUT_W(OUT_W), .NUM_LAYERS(8)) u8 (
    .clk(clk), .rst_n(rst_n), .wr_valid_i(wv8), .wr_data_i(wd8), .rd_row_i(rr8),
    .rd_data_o(rd8), .out_valid_o(ov8), .out_ready_i(rdy8), .out_data_o(od8),
    .out_last_o(ol8), .layer_o(lay8), .busy_o(busy8), .frame_done_o(fd8),
    .overflow_o(of8), .state_o(st8)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad = 0;
  logic [15:0] raw [N][N];          // matrix presented to u1 for the current frame
  logic [31:0] exp_q[$];            // expected u1 beats in order
  int beats_seen = 0;
  int frames_done = 0;
  logic done_pend = 1'b0;
  logic rnd_rdy = 1'b0;
  logic [31:0] first_beat = '0, last_beat = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [15:0] relu_m(input logic [15:0] v);
`ifdef MLP_BUF_RELU_EN
    return v[15] ? 16'h0000 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [255:0] exp_row1(input int r);
    logic [255:0] row;
    for (int c = 0; c < N; c++) row[c*16 +: 16] = relu_m(raw[r][c]);
    return row;
  endfunction

  // Row-major, two elements per beat, left column in the upper half.
  task automatic push_expect();
    for (int b = 0; b < BEATS; b++) begin
      exp_q.push_back({relu_m(raw[b/8][(b%8)*2]), relu_m(raw[b/8][(b%8)*2+1])});
    end
  endtask

  function automatic logic [15:0] val8(input int l, input int r, input int c);
    return 16'(l * 4096 + r * 16 + c);
  endfunction

  function automatic logic [255:0] row8(input int l, input int r);
    logic [255:0] row;
    for (int c = 0; c < N; c++) row[c*16 +: 16] = val8(l, r, c);
    return row;
  endfunction

  function automatic logic [31:0] beat8(input int l, input int b);
    return {val8(l, b/8, (b%8)*2), val8(l, b/8, (b%8)*2+1)};
  endfunction

  // ---------------- compare process for u1 ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      done_pend = 1'b0;
      beats_seen = 0;
    end else begin
      check("frame_done1", 256'(fd1), 256'(done_pend));
      if (done_pend) begin
        check("valid_after_last1", 256'(ov1), 256'(0));
        check("beat_count1", 256'(beats_seen), 256'(BEATS));
        frames_done++;
        beats_seen = 0;
      end
      done_pend = 1'b0;
      if (ov1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat1: unexpected beat %08h", od1);
        end else begin
          check("beat_data1", 256'(od1), 256'(exp_q[0]));
          check("beat_last1", 256'(ol1), 256'(exp_q.size() == 1));
          if (rdy1) begin
            if (beats_seen == 0) first_beat = od1;
            last_beat = od1;
            void'(exp_q.pop_front());
            beats_seen++;
            if (exp_q.size() == 0) done_pend = 1'b1;
          end
        end
      end else begin
        check("last_idle1", 256'(ol1), 256'(0));
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    rdy1 = 1'b1;
    forever begin
      @(posedge clk); #1;
      rdy1 = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic write_frame1();
    for (int g = 0; g < GPL; g++) begin
      @(posedge clk); #1;
      wv1 = 1'b1;
      for (int r = 0; r < RPW; r++)
        for (int c = 0; c < N; c++)
          wd1[(r*N + c)*DW +: DW] = raw[g*RPW + r][c];
      if (g == GPL - 1) push_expect();
    end
    @(posedge clk); #1;
    wv1 = 1'b0;
  endtask

  task automatic wait_frame1(input string name);
    int start;
    int n;
    start = frames_done;
    n = 0;
    while (frames_done == start && n < 2000) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (frames_done == start) begin
      bad++;
      $display("FAIL %s: frame_done not seen within 2000 cycles", name);
    end
  endtask

  task automatic fill_count();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        raw[r][c] = 16'(r * 16 + c);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    logic [31:0] f8, l8;
    rst_n = 1'b0;
    wv1 = 1'b0; wd1 = '0; rr1 = '0;
    wv8 = 1'b0; wd8 = '0; rr8 = 4'd3; rdy8 = 1'b1;
    f8 = '0; l8 = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_valid1", 256'(ov1), 256'(0));
    check("rst_busy1", 256'(busy1), 256'(0));
    check("rst_layer1", 256'(lay1), 256'(0));
    check("rst_overflow1", 256'(of1), 256'(0));
    check("rst_rd1", 256'(rd1), 256'(0));
    check("rst_state8", 256'(st8), 256'(IDLE));
    check("rst_layer8", 256'(lay8), 256'(0));
    check("rst_valid8", 256'(ov8), 256'(0));

    // single-layer frame, full throughput
    fill_count();
    write_frame1();
    @(negedge clk);
    check("t1_busy", 256'(busy1), 256'(1));
    check("t1_layer", 256'(lay1), 256'(1));
    check("t1_state", 256'(st1), 256'(DRAIN));
    wait_frame1("t1_done");
    check("t1_first_beat", 256'(first_beat), 256'(32'h0000_0001));
    check("t1_last_beat", 256'(last_beat), 256'(32'h00FE_00FF));
    @(negedge clk);
    check("t1_idle_busy", 256'(busy1), 256'(0));
    check("t1_idle_layer", 256'(lay1), 256'(0));
    rr1 = 4'd5;
    #1 check("t1_rd_row5", 256'(rd1), exp_row1(5));
    check("t1_rd_row5_lit", 256'(rd1[15:0]), 256'(16'h0050));

    // same frame with random backpressure
    rnd_rdy = 1'b1;
    write_frame1();
    wait_frame1("t2_done");
    rnd_rdy = 1'b0;
    check("t2_first_beat", 256'(first_beat), 256'(32'h0000_0001));
    check("t2_last_beat", 256'(last_beat), 256'(32'h00FE_00FF));

    // random data, groups pushed while draining
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        raw[r][c] = 16'($urandom_range(0, 65535));
    write_frame1();
    repeat (5) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      #1;
      wv1 = 1'b1;
      for (int i = 0; i < RPW*N; i++) wd1[i*DW +: DW] = 16'($urandom_range(0, 65535));
      @(posedge clk);
    end
    #1 wv1 = 1'b0;
    @(negedge clk);
    check("t4_overflow", 256'(of1), 256'(1));
    wait_frame1("t4_done");
    @(negedge clk);
    check("t4_overflow_sticky", 256'(of1), 256'(1));
    check("t4_busy", 256'(busy1), 256'(0));

    // eight-layer frame on u8
    for (int l = 0; l < 8; l++) begin
      for (int g = 0; g < GPL; g++) begin
        @(posedge clk); #1;
        wv8 = 1'b1;
        for (int r = 0; r < RPW; r++)
          for (int c = 0; c < N; c++)
            wd8[(r*N + c)*DW +: DW] = val8(l, g*RPW + r, c);
        @(posedge clk); #1;
        wv8 = 1'b0;
        @(negedge clk);
        if (l == 0 && g == 3) check("t3_rd_before_layer", 256'(rd8), 256'(0));
        if (l >= 1 && g < GPL - 1) check("t3_rd_prev_layer", 256'(rd8), row8(l - 1, 3));
        if (g < GPL - 1 || l < 7) begin
          check("t3_state_fill", 256'(st8), 256'(FILL));
          check("t3_no_valid", 256'(ov8), 256'(0));
        end
        if (g == GPL - 1) begin
          check("t3_layer_count", 256'(lay8), 256'(l + 1));
          check("t3_rd_new_layer", 256'(rd8), row8(l, 3));
        end
      end
    end
    check("t3_state_drain", 256'(st8), 256'(DRAIN));
    check("t3_valid_not_yet", 256'(ov8), 256'(0));
    n = 0;
    while (!ov8 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t3_first_valid_latency", 256'(n), 256'(1));
    check("t3_drain_layer", 256'(lay8), 256'(8));
    for (int b = 0; b < BEATS; b++) begin
      check("t3_valid", 256'(ov8), 256'(1));
      check("t3_beat", 256'(od8), 256'(beat8(7, b)));
      check("t3_last", 256'(ol8), 256'(b == BEATS - 1));
      if (b == 0) f8 = od8;
      if (b == BEATS - 1) l8 = od8;
      @(negedge clk);
    end
    check("t3_first_lit", 256'(f8), 256'(32'h7000_7001));
    check("t3_last_lit", 256'(l8), 256'(32'h70FE_70FF));
    check("t3_frame_done", 256'(fd8), 256'(1));
    check("t3_valid_end", 256'(ov8), 256'(0));
    check("t3_layer_end", 256'(lay8), 256'(0));
    check("t3_busy_end", 256'(busy8), 256'(0));
    @(negedge clk);
    check("t3_done_pulse", 256'(fd8), 256'(0));

    // reset in the middle of a drain
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        raw[r][c] = 16'((r * 16 + c) ^ 16'h0A5A);
    write_frame1();
    n = 0;
    while (beats_seen < 40 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("t5_reached_beat40", 256'(beats_seen >= 40), 256'(1));
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_valid", 256'(ov1), 256'(0));
    check("t5_busy", 256'(busy1), 256'(0));
    check("t5_layer", 256'(lay1), 256'(0));
    check("t5_overflow_clr", 256'(of1), 256'(0));
    check("t5_rd_cleared", 256'(rd1), 256'(0));
    repeat (3) begin
      @(negedge clk);
      check("t5_no_done", 256'(fd1), 256'(0));
    end

    // clean frame after reset, with negative elements
    fill_count();
    raw[0][0] = 16'h8001;
    raw[0][1] = 16'h0005;
    raw[3][7] = 16'hFFFF;
    write_frame1();
    wait_frame1("t6_done");
`ifdef MLP_BUF_RELU_EN
    check("t6_first_beat", 256'(first_beat), 256'(32'h0000_0005));
`else
    check("t6_first_beat", 256'(first_beat), 256'(32'h8001_0005));
`endif
    check("t6_last_beat", 256'(last_beat), 256'(32'h00FE_00FF));
    rr1 = 4'd0;
    #1;
`ifdef MLP_BUF_RELU_EN
    check("t6_rd_elem0", 256'(rd1[15:0]), 256'(16'h0000));
`else
    check("t6_rd_elem0", 256'(rd1[15:0]), 256'(16'h8001));
`endif
    rr1 = 4'd3;
    #1 check("t6_rd_row3", 256'(rd1), exp_row1(3));

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
